interface_botoes: RTL and testbench

INTERFACE_BOTOES -- requirements
Module: interface_botoes

---
 rtl/interface_botoes.sv | 121 ++++++++++++
 tb/tb_interface_botoes.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interface_botoes.sv
// Button interface: 2-flop synchronizer, debounce FSM, one pulse per accepted single-button play.
// A play is accepted after DEBOUNCE_CICLOS stable samples; a debounced release re-arms the next play.
module interface_botoes #(
    parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       habilita,
    output logic       jogada_feita,
    output logic [3:0] jogada,
    output logic       erro_multiplo,
    output logic       db_tem_jogada,
    output logic [3:0] db_estado
);

    localparam int unsigned CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    localparam logic [2:0] ESPERA = 3'd0;
    localparam logic [2:0] FILTRA = 3'd1;
    localparam logic [2:0] EMITE  = 3'd2;
    localparam logic [2:0] LIBERA = 3'd3;
    localparam logic [2:0] ERRO   = 3'd4;

    logic [3:0]    sync_meta_q;
    logic [3:0]    botoes_s_q;
    logic [2:0]    estado_q, estado_d;
    logic [CW-1:0] cont_q, cont_d;
    logic [3:0]    amostra_q, amostra_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          amostra_onehot;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta_q <= 4'b0000;
            botoes_s_q  <= 4'b0000;
            estado_q    <= LIBERA;
            cont_q      <= '0;
            amostra_q   <= 4'b0000;
            jogada_q    <= 4'b0000;
        end else begin
            sync_meta_q <= botoes;
            botoes_s_q  <= sync_meta_q;
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            amostra_q   <= amostra_d;
            jogada_q    <= jogada_d;
        end
    end

    assign amostra_onehot = (amostra_q != 4'b0000) &&
                            ((amostra_q & (amostra_q - 4'd1)) == 4'b0000);

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        amostra_d = amostra_q;
        jogada_d  = jogada_q;
        case (estado_q)
            ESPERA: begin
                if (!habilita) begin
                    estado_d = LIBERA;
                    cont_d   = '0;
                end else if (botoes_s_q != 4'b0000) begin
                    estado_d  = FILTRA;
                    amostra_d = botoes_s_q;
                    cont_d    = '0;
                end
            end
            FILTRA: begin
                if (!habilita) begin
                    estado_d = LIBERA;
                    cont_d   = '0;
                end else if (botoes_s_q == 4'b0000) begin
                    estado_d = ESPERA;
                    cont_d   = '0;
                end else if (botoes_s_q != amostra_q) begin
                    amostra_d = botoes_s_q;
                    cont_d    = '0;
                end else if (cont_q != CNT_MAX) begin
                    cont_d = cont_q + 1'b1;
                end else begin
                    estado_d = amostra_onehot ? EMITE : ERRO;
                    cont_d   = '0;
                end
            end
            EMITE: begin
                jogada_d = amostra_q;
                estado_d = LIBERA;
                cont_d   = '0;
            end
            ERRO: begin
                estado_d = LIBERA;
                cont_d   = '0;
            end
            LIBERA: begin
                // Release must be continuous: any nonzero sample restarts the count.
                if (botoes_s_q != 4'b0000) begin
                    cont_d = '0;
                end else if (cont_q == CNT_MAX) begin
                    estado_d = ESPERA;
                    cont_d   = '0;
                end else begin
                    cont_d = cont_q + 1'b1;
                end
            end
            default: begin
                estado_d = LIBERA;
                cont_d   = '0;
            end
        endcase
    end

    assign jogada_feita  = (estado_q == EMITE);
    assign erro_multiplo = (estado_q == ERRO);
    assign jogada        = jogada_q;
    assign db_tem_jogada = |botoes_s_q;
    assign db_estado     = {1'b0, estado_q};

endmodule

// File: tb/tb_interface_botoes.sv
// Directed bench for interface_botoes with DEBOUNCE_CICLOS = 4.
module tb_interface_botoes;

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       jogada_feita;
    logic [3:0] jogada;
    logic       erro_multiplo;
    logic       db_tem_jogada;
    logic [3:0] db_estado;

    int n_cmp;
    int n_bad;
    int cnt_feita;
    int cnt_erro;
    int cnt_both;
    int k_feita;
    int k_erro;

    interface_botoes #(.DEBOUNCE_CICLOS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .botoes        (botoes),
        .habilita      (habilita),
        .jogada_feita  (jogada_feita),
        .jogada        (jogada),
        .erro_multiplo (erro_multiplo),
        .db_tem_jogada (db_tem_jogada),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_counts();
        cnt_feita = 0;
        cnt_erro  = 0;
        cnt_both  = 0;
        k_feita   = 0;
        k_erro    = 0;
    endtask

    // Advance one edge; k is the edge index within the current scenario.
    task automatic tick(input int k);
        @(posedge clock);
        #1;
        if (jogada_feita) begin
            cnt_feita++;
            if (k_feita == 0) k_feita = k;
        end
        if (erro_multiplo) begin
            cnt_erro++;
            if (k_erro == 0) k_erro = k;
        end
        if (jogada_feita && erro_multiplo) cnt_both++;
    endtask

    task automatic release_buttons();
        botoes = 4'b0000;
        for (int k = 1; k <= 8; k++) tick(k);
        n_cmp++;
        if (db_estado !== 4'd0) begin
            n_bad++;
            $display("FAIL release_to_espera: db_estado=%0d expected 0", db_estado);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; habilita = 1'b1; botoes = 4'b0000;
        clear_counts();
        tick(1); tick(2);
        n_cmp++;
        if (db_estado !== 4'd3 || jogada !== 4'b0000 || jogada_feita !== 1'b0 ||
            erro_multiplo !== 1'b0 || db_tem_jogada !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: estado=%0d jogada=%b feita=%b erro=%b tem=%b expected 3 0000 0 0 0",
                     db_estado, jogada, jogada_feita, erro_multiplo, db_tem_jogada);
        end
        reset = 1'b0;
        clear_counts();
        for (int k = 1; k <= 6; k++) begin
            tick(k);
            if (k == 3) begin
                n_cmp++;
                if (db_estado !== 4'd3) begin
                    n_bad++;
                    $display("FAIL reset_release_wait: db_estado=%0d expected 3", db_estado);
                end
            end
        end
        n_cmp++;
        if (db_estado !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_to_espera: db_estado=%0d expected 0", db_estado);
        end
        n_cmp++;
        if (cnt_feita + cnt_erro !== 0) begin
            n_bad++;
            $display("FAIL reset_no_pulse: pulses=%0d expected 0", cnt_feita + cnt_erro);
        end
    endtask

    task automatic test_single_press();
        clear_counts();
        habilita = 1'b1;
        botoes = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick(k);
            if (k == 2) begin
                n_cmp++;
                if (db_tem_jogada !== 1'b1) begin
                    n_bad++;
                    $display("FAIL press_tem_jogada: db_tem_jogada=%b expected 1", db_tem_jogada);
                end
            end
        end
        n_cmp++;
        if (cnt_feita !== 1 || k_feita !== 7) begin
            n_bad++;
            $display("FAIL press_pulse: count=%0d at_edge=%0d expected 1 at 7", cnt_feita, k_feita);
        end
        n_cmp++;
        if (jogada !== 4'b0100 || db_estado !== 4'd3 || cnt_erro !== 0) begin
            n_bad++;
            $display("FAIL press_after: jogada=%b estado=%0d erros=%0d expected 0100 3 0",
                     jogada, db_estado, cnt_erro);
        end
        release_buttons();
    endtask

    task automatic test_bounce();
        clear_counts();
        for (int k = 1; k <= 12; k++) begin
            botoes = (((k - 1) / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
            tick(k);
        end
        n_cmp++;
        if (cnt_feita + cnt_erro !== 0) begin
            n_bad++;
            $display("FAIL bounce_no_pulse: pulses=%0d expected 0", cnt_feita + cnt_erro);
        end
        clear_counts();
        botoes = 4'b0100;
        for (int k = 1; k <= 20; k++) tick(k);
        n_cmp++;
        if (cnt_feita !== 1 || k_feita !== 7 || jogada !== 4'b0100) begin
            n_bad++;
            $display("FAIL bounce_stable: count=%0d at_edge=%0d jogada=%b expected 1 7 0100",
                     cnt_feita, k_feita, jogada);
        end
        release_buttons();
    endtask

    task automatic test_each_button();
        logic [3:0] vec [3];
        vec[0] = 4'b0001; vec[1] = 4'b1000; vec[2] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            clear_counts();
            botoes = vec[i];
            for (int k = 1; k <= 10; k++) tick(k);
            n_cmp++;
            if (cnt_feita !== 1 || k_feita !== 7 || jogada !== vec[i]) begin
                n_bad++;
                $display("FAIL button_%0d: count=%0d at_edge=%0d jogada=%b expected 1 7 %b",
                         i, cnt_feita, k_feita, jogada, vec[i]);
            end
            release_buttons();
        end
    endtask

    task automatic test_multi_press();
        logic [3:0] prev;
        prev = jogada;
        clear_counts();
        botoes = 4'b0011;
        for (int k = 1; k <= 20; k++) begin
            tick(k);
            if (k == 7) begin
                n_cmp++;
                if (db_estado !== 4'd4) begin
                    n_bad++;
                    $display("FAIL multi_erro_state: db_estado=%0d expected 4", db_estado);
                end
            end
        end
        n_cmp++;
        if (cnt_erro !== 1 || k_erro !== 7 || cnt_feita !== 0) begin
            n_bad++;
            $display("FAIL multi_pulses: erro=%0d at_edge=%0d feita=%0d expected 1 7 0",
                     cnt_erro, k_erro, cnt_feita);
        end
        n_cmp++;
        if (jogada !== prev) begin
            n_bad++;
            $display("FAIL multi_jogada_kept: jogada=%b expected %b", jogada, prev);
        end
        release_buttons();
    endtask

    task automatic test_habilita_low();
        clear_counts();
        habilita = 1'b0;
        botoes = 4'b0001;
        for (int k = 1; k <= 10; k++) tick(k);
        n_cmp++;
        if (db_estado !== 4'd3) begin
            n_bad++;
            $display("FAIL hab_low_state: db_estado=%0d expected 3", db_estado);
        end
        habilita = 1'b1;
        for (int k = 11; k <= 20; k++) tick(k);
        n_cmp++;
        if (cnt_feita + cnt_erro !== 0 || db_estado !== 4'd3) begin
            n_bad++;
            $display("FAIL hab_held_no_pulse: pulses=%0d estado=%0d expected 0 3",
                     cnt_feita + cnt_erro, db_estado);
        end
        release_buttons();
        clear_counts();
        botoes = 4'b0001;
        for (int k = 1; k <= 10; k++) tick(k);
        n_cmp++;
        if (cnt_feita !== 1 || k_feita !== 7 || jogada !== 4'b0001) begin
            n_bad++;
            $display("FAIL hab_repress: count=%0d at_edge=%0d jogada=%b expected 1 7 0001",
                     cnt_feita, k_feita, jogada);
        end
        release_buttons();
    endtask

    task automatic test_reset_in_filtra();
        clear_counts();
        botoes = 4'b0010;
        for (int k = 1; k <= 4; k++) tick(k);
        n_cmp++;
        if (db_estado !== 4'd1) begin
            n_bad++;
            $display("FAIL filtra_reached: db_estado=%0d expected 1", db_estado);
        end
        reset = 1'b1;
        tick(5);
        n_cmp++;
        if (db_estado !== 4'd3 || jogada !== 4'b0000 || jogada_feita !== 1'b0 ||
            erro_multiplo !== 1'b0 || db_tem_jogada !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_press: estado=%0d jogada=%b feita=%b erro=%b tem=%b expected 3 0000 0 0 0",
                     db_estado, jogada, jogada_feita, erro_multiplo, db_tem_jogada);
        end
        reset = 1'b0;
        for (int k = 6; k <= 18; k++) tick(k);
        n_cmp++;
        if (cnt_feita + cnt_erro !== 0 || db_estado !== 4'd3) begin
            n_bad++;
            $display("FAIL reset_held_no_pulse: pulses=%0d estado=%0d expected 0 3",
                     cnt_feita + cnt_erro, db_estado);
        end
        release_buttons();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_counts();
        reset = 1'b1;
        habilita = 1'b1;
        botoes = 4'b0000;
        test_reset();
        test_single_press();
        test_bounce();
        test_each_button();
        test_multi_press();
        test_habilita_low();
        test_reset_in_filtra();
        n_cmp++;
        if (cnt_both !== 0) begin
            n_bad++;
            $display("FAIL pulses_exclusive: both_high_cycles=%0d expected 0", cnt_both);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
